glb_bank_rd_responder: RTL and testbench
========================================

// Module: glb_bank_rd_responder
// PURPOSE
//  Bank-side responder for GLB read traffic. Consumes read-request packets (rd_src, rd_en, rd_addr).
//  Reads hitting this tile/bank are issued to the bank SRAM macro.
//  Each read's rd_src tag travels alongside the SRAM access pipeline.
//  Returns read-response packets (rd_src, rd_data, rd_data_valid) in request order, with credit-based backpressure.
//  One instance sits per bank, between the tile's rdrq router and its rdrs return path.
// PARAMETERS
//  SRAM_LATENCY  2  cycles from sram_ren to valid sram_rdata; legal range >=1
//  FIFO_DEPTH    4  response buffer entries; must be >= SRAM_LATENCY+2 for full throughput
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous active-high reset
//  glb_tile_id   in   4   this tile's id, quasi-static
//  bank_id       in   1   this bank's index within the tile, quasi-static
//  rdrq_en       in   1   read request valid
//  rdrq_addr     in   22  GLB byte address: [21:18] tile, [17] bank, [16:3] word, [2:0] byte
//  rdrq_src      in   4   requesting tile id, returned unchanged as rdrs_src
//  rdrq_ready    out  1   credit available; a hit is accepted only when high
//  sram_ren      out  1   SRAM read enable
//  sram_addr     out  14  SRAM word address
//  sram_rdata    in   64  SRAM read data, valid SRAM_LATENCY cycles after sram_ren
//  rdrs_valid    out  1   response valid (rd_data_valid)
//  rdrs_data     out  64  response data
//  rdrs_src      out  4   response tag
//  rdrs_ready    in   1   downstream accepts the response
// BEHAVIOUR
//  - Clocking and reset: single clock. All state resets synchronously on reset=1.
//    During reset and the cycle it is sampled: rdrq_ready=0, sram_ren=0, rdrs_valid=0.
//    While reset=1, sram_addr, rdrs_data and rdrs_src are 0.
//  - hit = rdrq_en && rdrq_addr[21:18]==glb_tile_id && rdrq_addr[17]==bank_id.
//  - accept = hit && rdrq_ready.
//  - Requests that miss are ignored entirely: no SRAM access, no state change.
//  - A hit that is not accepted is dropped; the upstream router holds it until rdrq_ready=1.
//  - sram_ren = accept (combinational, same cycle). sram_addr = rdrq_addr[16:3]. Byte offset is ignored.
//  - Tag pipeline: SRAM_LATENCY-stage shift register of {vld, src}, loaded with {accept, rdrq_src}.
//  - When the last stage has vld=1, {src, sram_rdata} is pushed into the response FIFO that cycle.
//  - Response FIFO: FIFO_DEPTH entries, registered outputs, head drives rdrs_*.
//    A pop occurs when rdrs_valid && rdrs_ready.
//    rdrs_* hold stable while rdrs_valid && !rdrs_ready.
//  - Latency: accept in cycle T gives rdrs_valid at T+SRAM_LATENCY+1, minimum.
//  - Credit counter cnt, width $clog2(FIFO_DEPTH+1):
//    - counts in-flight reads plus FIFO occupancy;
//    - +1 on accept, -1 on pop, unchanged when both occur in the same cycle;
//    - rdrq_ready = !reset && cnt < FIFO_DEPTH.
//    - The FIFO therefore never overflows. A push into a full FIFO is impossible by construction; assert it.
//  - Ordering: responses leave strictly in acceptance order.
//  - Throughput: one response per cycle when rdrs_ready is held at 1.
//  - Empty FIFO: rdrs_valid=0. rdrs_data/rdrs_src keep their last value; they are not cleared.
//  - Reset mid-operation: in-flight tags and FIFO contents are discarded and cnt=0.
//    sram_rdata arriving after reset is ignored because the tag vld bits are cleared.
// TESTING
//  - Single hit:
//    - Stimulus: glb_tile_id=3, bank_id=1; rdrq addr=22'h0E0108, src=5 at T; SRAM returns 64'hDEAD_BEEF_0000_0001.
//    - Response: sram_ren=1 and sram_addr=14'h0021 at T; rdrs_valid=1, src=5 with that data at T+3.
//  - Miss:
//    - Stimulus: addr tile=2, or bank=0 with glb_tile_id=3, bank_id=1.
//    - Response: sram_ren stays 0, cnt unchanged, no rdrs_valid.
//  - Backpressure:
//    - Stimulus: rdrs_ready=0; 5 back-to-back hits.
//    - Response: 4 accepted, rdrq_ready=0 from the 5th cycle, 5th not issued.
//    - Release: raise rdrs_ready; 4 responses drain in order, then rdrq_ready=1.
//  - Simultaneous accept and pop:
//    - Stimulus: cnt=3 with a hit accepted and a response popped in the same cycle.
//    - Response: cnt stays 3 and data order is preserved.
//  - Streaming:
//    - Stimulus: 8 consecutive hits with src=0..7, rdrs_ready=1.
//    - Response: 8 consecutive rdrs_valid cycles with src 0..7; rdrq_ready never drops.
//  - Reset mid-flight:
//    - Stimulus: accept at T, assert reset at T+1.
//    - Response: no rdrs_valid is ever emitted for that read, cnt=0, rdrq_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/glb_bank_rd_responder.sv
// Bank-side GLB read responder: issues local read hits to the bank SRAM, carries the
// requester tag alongside the SRAM latency, and returns in-order responses under credit flow control.
module glb_bank_rd_responder #(
  parameter int SRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  glb_tile_id,
  input  logic        bank_id,
  input  logic        rdrq_en,
  input  logic [21:0] rdrq_addr,
  input  logic [3:0]  rdrq_src,
  output logic        rdrq_ready,
  output logic        sram_ren,
  output logic [13:0] sram_addr,
  input  logic [63:0] sram_rdata,
  output logic        rdrs_valid,
  output logic [63:0] rdrs_data,
  output logic [3:0]  rdrs_src,
  input  logic        rdrs_ready
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  // The output register is one FIFO entry, so the backing array holds the rest.
  localparam int ARR_D  = (FIFO_DEPTH > 1) ? FIFO_DEPTH - 1 : 1;
  localparam int PTR_W  = (ARR_D > 1) ? $clog2(ARR_D) : 1;
  localparam int ACNT_W = $clog2(ARR_D + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ARR_D - 1)) ? '0 : p + 1'b1;
  endfunction

  logic               w_hit;
  logic               w_accept;
  logic               w_pop;
  logic               w_push;
  logic [3:0]         w_push_src;
  logic               w_out_free;
  logic               w_arr_empty;
  logic               w_load_arr;
  logic               w_load_push;
  logic               w_arr_wr;
  logic [CNT_W-1:0]   w_occ;
  logic               w_unused_byte;

  logic [CNT_W-1:0]   r_cnt;
  logic               r_tag_vld [SRAM_LATENCY];
  logic [3:0]         r_tag_src [SRAM_LATENCY];

  logic [3:0]         r_mem_src  [ARR_D];
  logic [63:0]        r_mem_data [ARR_D];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [ACNT_W-1:0]  r_arr_cnt;
  logic               r_out_vld;
  logic [3:0]         r_out_src;
  logic [63:0]        r_out_data;

  assign w_unused_byte = ^rdrq_addr[2:0];

  assign w_hit      = rdrq_en && (rdrq_addr[21:18] == glb_tile_id) && (rdrq_addr[17] == bank_id);
  assign rdrq_ready = !reset && (r_cnt < CNT_W'(FIFO_DEPTH));
  assign w_accept   = w_hit && rdrq_ready;

  assign sram_ren   = w_accept;
  assign sram_addr  = reset ? 14'd0 : rdrq_addr[16:3];

  assign rdrs_valid = r_out_vld && !reset;
  assign rdrs_data  = reset ? 64'd0 : r_out_data;
  assign rdrs_src   = reset ? 4'd0 : r_out_src;
  assign w_pop      = rdrs_valid && rdrs_ready;

  // Credit counter: in-flight reads plus buffered responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Tag pipeline stage boundary: {vld, src} tracks the SRAM access latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SRAM_LATENCY; i++) begin
        r_tag_vld[i] <= 1'b0;
        r_tag_src[i] <= 4'd0;
      end
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag_src[0] <= rdrq_src;
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_src[i] <= r_tag_src[i-1];
      end
    end
  end

  assign w_push     = r_tag_vld[SRAM_LATENCY-1];
  assign w_push_src = r_tag_src[SRAM_LATENCY-1];

  assign w_out_free  = !r_out_vld || w_pop;
  assign w_arr_empty = (r_arr_cnt == '0);
  assign w_load_arr  = w_out_free && !w_arr_empty;
  // With nothing queued ahead, fresh SRAM data goes straight into the output register.
  assign w_load_push = w_out_free && w_arr_empty && w_push;
  assign w_arr_wr    = w_push && !w_load_push;
  assign w_occ       = CNT_W'(r_arr_cnt) + CNT_W'(r_out_vld);

  always_ff @(posedge clk) begin
    if (w_arr_wr) begin
      r_mem_src[r_wr_ptr]  <= w_push_src;
      r_mem_data[r_wr_ptr] <= sram_rdata;
    end
  end

  // Response FIFO stage boundary: array pointers and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_arr_cnt  <= '0;
      r_out_vld  <= 1'b0;
      r_out_src  <= 4'd0;
      r_out_data <= 64'd0;
    end else begin
      if (w_arr_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_load_arr) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_arr_wr, w_load_arr})
        2'b10:   r_arr_cnt <= r_arr_cnt + 1'b1;
        2'b01:   r_arr_cnt <= r_arr_cnt - 1'b1;
        default: r_arr_cnt <= r_arr_cnt;
      endcase
      if (w_load_arr) begin
        r_out_vld  <= 1'b1;
        r_out_src  <= r_mem_src[r_rd_ptr];
        r_out_data <= r_mem_data[r_rd_ptr];
      end else if (w_load_push) begin
        r_out_vld  <= 1'b1;
        r_out_src  <= w_push_src;
        r_out_data <= sram_rdata;
      end else if (w_pop) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  // Credits bound occupancy, so a push always finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    w_push |-> (w_occ < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_glb_bank_rd_responder.sv
// Randomized and directed bench for glb_bank_rd_responder, checked against a
// transaction-level queue model of outstanding reads and their earliest return cycle.
module tb_glb_bank_rd_responder;

  localparam int L = 2;
  localparam int D = 4;

  typedef struct {
    logic [3:0]  src;
    logic [63:0] dat;
    int          avail;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  glb_tile_id;
  logic        bank_id;
  logic        rdrq_en;
  logic [21:0] rdrq_addr;
  logic [3:0]  rdrq_src;
  logic        rdrq_ready;
  logic        sram_ren;
  logic [13:0] sram_addr;
  logic [63:0] sram_rdata;
  logic        rdrs_valid;
  logic [63:0] rdrs_data;
  logic [3:0]  rdrs_src;
  logic        rdrs_ready;

  glb_bank_rd_responder #(.SRAM_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .glb_tile_id (glb_tile_id),
    .bank_id     (bank_id),
    .rdrq_en     (rdrq_en),
    .rdrq_addr   (rdrq_addr),
    .rdrq_src    (rdrq_src),
    .rdrq_ready  (rdrq_ready),
    .sram_ren    (sram_ren),
    .sram_addr   (sram_addr),
    .sram_rdata  (sram_rdata),
    .rdrs_valid  (rdrs_valid),
    .rdrs_data   (rdrs_data),
    .rdrs_src    (rdrs_src),
    .rdrs_ready  (rdrs_ready)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [63:0] sched_dat [16];
  logic        sched_vld [16];
  rsp_t        q[$];
  logic        force_vld = 1'b0;
  logic [63:0] force_dat = 64'd0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance the model.
  task automatic step(input logic en, input logic [21:0] a, input logic [3:0] s,
                      input logic rdy, input logic rs);
    logic hit, exp_rdy, acc, exp_vld;
    rsp_t r;
    rdrq_en    = en;
    rdrq_addr  = a;
    rdrq_src   = s;
    rdrs_ready = rdy;
    reset      = rs;
    if (sched_vld[cyc % 16]) sram_rdata = sched_dat[cyc % 16];
    else                     sram_rdata = {$urandom, $urandom};
    sched_vld[cyc % 16] = 1'b0;

    @(negedge clk);
    hit     = en && (a[21:18] == glb_tile_id) && (a[17] == bank_id);
    exp_rdy = !rs && (q.size() < D);
    acc     = hit && exp_rdy;
    exp_vld = 1'b0;
    if (!rs && q.size() > 0) exp_vld = (q[0].avail <= cyc);

    chk_eq("rdrq_ready", rdrq_ready, exp_rdy);
    chk_eq("sram_ren",   sram_ren,   acc);
    chk_eq("rdrs_valid", rdrs_valid, exp_vld);
    if (rs) begin
      chk_eq("rst_sram_addr", sram_addr, 0);
      chk_eq("rst_rdrs_data", rdrs_data, 0);
      chk_eq("rst_rdrs_src",  rdrs_src,  0);
    end else if (acc) begin
      chk_eq("sram_addr", sram_addr, a[16:3]);
    end
    if (exp_vld) begin
      chk_eq("rdrs_src",  rdrs_src,  q[0].src);
      chk_eq("rdrs_data", rdrs_data, q[0].dat);
    end

    if (rs) begin
      q.delete();
    end else begin
      if (exp_vld && rdy) void'(q.pop_front());
      if (acc) begin
        r.src   = s;
        r.dat   = force_vld ? force_dat : {$urandom, $urandom};
        r.avail = cyc + L + 1;
        q.push_back(r);
        sched_dat[(cyc + L) % 16] = r.dat;
        sched_vld[(cyc + L) % 16] = 1'b1;
        force_vld = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [21:0] hit_addr();
    logic [13:0] w;
    logic [2:0]  b;
    w = 14'($urandom);
    b = 3'($urandom);
    return {glb_tile_id, bank_id, w, b};
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      sched_vld[i] = 1'b0;
      sched_dat[i] = 64'd0;
    end
    reset = 1'b1; glb_tile_id = 4'd3; bank_id = 1'b1;
    rdrq_en = 1'b0; rdrq_addr = '0; rdrq_src = '0; rdrs_ready = 1'b0; sram_rdata = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) step(1'b1, 22'h0E0108, 4'd1, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Single hit with the reference data word.
    force_vld = 1'b1;
    force_dat = 64'hDEAD_BEEF_0000_0001;
    step(1'b1, 22'h0E0108, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Misses: wrong tile, then wrong bank.
    step(1'b1, {4'd2, 1'b1, 14'h0055, 3'd0}, 4'd6, 1'b1, 1'b0);
    step(1'b1, {4'd3, 1'b0, 14'h0066, 3'd0}, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: five hits with the response path stalled, then release.
    for (int i = 0; i < 5; i++) step(1'b1, hit_addr(), 4'(i + 8), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Accept and pop in the same cycle with three outstanding.
    for (int i = 0; i < 3; i++) step(1'b1, hit_addr(), 4'(i + 1), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, hit_addr(), 4'd4, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    step(1'b1, hit_addr(), 4'd5, 1'b0, 1'b0);
    step(1'b1, hit_addr(), 4'd6, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Streaming: eight consecutive hits at full rate.
    for (int i = 0; i < 8; i++) step(1'b1, hit_addr(), 4'(i), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset while a read is in flight.
    step(1'b1, hit_addr(), 4'd9, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic, including identity changes and rare resets.
    glb_tile_id = 4'($urandom);
    bank_id     = 1'($urandom);
    for (int i = 0; i < 2000; i++) begin
      logic        en, rdy, rs;
      logic [21:0] a;
      if (i == 1000) begin
        glb_tile_id = 4'($urandom);
        bank_id     = 1'($urandom);
      end
      en  = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 3) != 0) ? hit_addr() : 22'($urandom);
      rdy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
      rs  = ($urandom_range(0, 299) == 0);
      step(en, a, 4'($urandom), rdy, rs);
    end
    for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk_eq("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
